// File: rtl/btn_conditioner.sv
// btn_conditioner
// Turns the five raw, active-low front-panel buttons into clean pressed levels
// and single-cycle press strobes for the time-set logic.
// Each button has a two-flop synchroniser, a counter-based debouncer and a
// rising-edge press detector.
// Optional hold-to-repeat on the REPEAT_MASK buttons is compiled in only when
// the macro BTN_AUTOREPEAT_EN is defined. Without it, o_press pulses exactly
// once per accepted press.
// All outputs come straight from flops. i_btn_n never reaches an output
// combinationally.

module btn_conditioner #(
  parameter int                 NUM_BTN      = 5,
  parameter int                 DB_CYCLES    = 240000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK  = 5'b00110,
  parameter int                 REPEAT_DELAY = 6000000,
  parameter int                 REPEAT_RATE  = 1200000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_BTN-1:0] i_btn_n,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press
);

  // Debounce counter only has to reach DB_CYCLES-1.
  localparam int              DB_W    = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  // One repeat counter width serves both the initial delay and the repeat period.
  localparam int               RPT_MAX     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int               RPT_W       = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_DELAY_LD = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RATE_LD  = RPT_W'(REPEAT_RATE - 1);
`endif

  // Elaboration-time parameter sanity checks.
  if (DB_CYCLES < 2) begin : g_bad_db
    $error("btn_conditioner: DB_CYCLES must be at least 2");
  end
  if ((REPEAT_MASK != '0) && ((REPEAT_DELAY < 2) || (REPEAT_RATE < 2))) begin : g_bad_rpt
    $error("btn_conditioner: REPEAT_DELAY and REPEAT_RATE must be at least 2");
  end

  // Synchroniser flops. They reset to 1 so every button looks released.
  logic [NUM_BTN-1:0] sync1_reg;
  logic [NUM_BTN-1:0] sync2_reg;

  // Two-flop synchroniser for the asynchronous button pins.
  // Only the second stage is used downstream.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= i_btn_n;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    // stable_n_reg holds the accepted pin value (active-low).
    logic [DB_W-1:0] db_cnt_reg;
    logic            stable_n_reg;
    logic            differ;
    logic            accept;
    logic            rise;

    assign differ = sync2_reg[gi] ^ stable_n_reg;
    // Accept a change once the disagreement has lasted DB_CYCLES cycles.
    assign accept = differ && (db_cnt_reg == DB_LAST);
    // A change to a low pin is a press.
    assign rise   = accept && !sync2_reg[gi];

    // Debounce. Any agreement clears the run counter, so a short glitch is
    // forgotten and the next disagreement counts from zero again.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        db_cnt_reg   <= '0;
        stable_n_reg <= 1'b1;
      end else if (!differ) begin
        db_cnt_reg   <= '0;
      end else if (accept) begin
        stable_n_reg <= sync2_reg[gi];
        db_cnt_reg   <= '0;
      end else begin
        db_cnt_reg   <= db_cnt_reg + DB_W'(1);
      end
    end

    assign o_level[gi] = ~stable_n_reg;

`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_MASK[gi]) begin : g_rpt
      logic [RPT_W-1:0] rpt_cnt_reg;
      logic             press_reg;
      logic             fall;

      assign fall = accept && sync2_reg[gi];

      // Press strobe plus hold-to-repeat.
      // The counter is loaded on the press edge and counts down while the
      // button stays pressed. Each time it reaches 0 it fires a strobe and
      // reloads with the repeat period.
      // A release clears the counter silently.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          rpt_cnt_reg <= '0;
          press_reg   <= 1'b0;
        end else begin
          press_reg <= 1'b0;
          if (rise) begin
            rpt_cnt_reg <= RPT_DELAY_LD;
            press_reg   <= 1'b1;
          end else if (fall) begin
            rpt_cnt_reg <= '0;
          end else if (!stable_n_reg) begin
            if (rpt_cnt_reg == '0) begin
              rpt_cnt_reg <= RPT_RATE_LD;
              press_reg   <= 1'b1;
            end else begin
              rpt_cnt_reg <= rpt_cnt_reg - RPT_W'(1);
            end
          end
        end
      end

      assign o_press[gi] = press_reg;
    end else begin : g_norpt
      logic press_reg;

      // Single strobe per accepted press on a non-repeating button.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          press_reg <= 1'b0;
        end else begin
          press_reg <= rise;
        end
      end

      assign o_press[gi] = press_reg;
    end
`else
    logic press_reg;

    // Single strobe per accepted press. No repeat logic in this build.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        press_reg <= 1'b0;
      end else begin
        press_reg <= rise;
      end
    end

    assign o_press[gi] = press_reg;
`endif
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
// Directed test of btn_conditioner with short debounce and repeat timing.
// Expected repeat behaviour follows BTN_AUTOREPEAT_EN.

module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_n = 5'b11111;
  logic [4:0] level;
  logic [4:0] press;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt;
  logic [4:0] acc;
  logic       exp_bit;

  btn_conditioner #(
    .NUM_BTN      (5),
    .DB_CYCLES    (4),
    .REPEAT_MASK  (5'b00110),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (8)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_btn_n (btn_n),
    .o_level (level),
    .o_press (press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for three cycles with every button released.
    tick(3);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_press", 32'(press), 32'h0);
    chk("rst_sync1", 32'(dut.sync1_reg), 32'h1f);
    chk("rst_sync2", 32'(dut.sync2_reg), 32'h1f);
    rst = 1'b0;
    tick(2);
    chk("idle_level", 32'(level), 32'h0);
    $display("step reset: done");

    // Write button: single press strobe, then no repeats while held.
    btn_n[0] = 1'b0;
    tick(5);
    chk("wr_level_early", 32'(level), 32'h0);
    chk("wr_press_early", 32'(press), 32'h0);
    tick(1);
    chk("wr_level", 32'(level), 32'h01);
    chk("wr_press", 32'(press), 32'h01);
    tick(1);
    chk("wr_press_end", 32'(press), 32'h00);
    chk("wr_level_held", 32'(level), 32'h01);
    cnt = 0;
    for (int c = 0; c < 44; c++) begin
      tick(1);
      cnt += int'(press[0]);
    end
    chk("wr_no_repeat", 32'(cnt), 32'd0);
    btn_n[0] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      cnt += int'(press[0]);
    end
    chk("wr_rel_level_early", 32'(level), 32'h01);
    tick(1);
    cnt += int'(press[0]);
    chk("wr_rel_level", 32'(level), 32'h00);
    chk("wr_rel_no_strobe", 32'(cnt), 32'd0);
    $display("step write press/release: done");

    // Three-cycle glitch on select-inc is one cycle too short and is discarded.
    btn_n[3] = 1'b0;
    tick(3);
    btn_n[3] = 1'b1;
    acc = '0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      acc |= level | press;
    end
    chk("glitch3_ignored", 32'(acc), 32'h0);

    // Four low cycles is the shortest accepted press.
    btn_n[3] = 1'b0;
    tick(4);
    btn_n[3] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      cnt += int'(press[3]);
    end
    chk("pulse4_strobes", 32'(cnt), 32'd1);
    chk("pulse4_released", 32'(level), 32'h0);
    $display("step glitch boundary: done");

    // Value-inc held: press at P, repeats at P+20, +28, +36, +44.
    // The release is timed so the level falls at P+50, before P+52.
    btn_n[1] = 1'b0;
    tick(6);
    chk("rpt_first", 32'(press), 32'h02);
    cnt = 1;
    for (int c = 1; c <= 60; c++) begin
      tick(1);
      exp_bit = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      exp_bit = (c == 20) || (c == 28) || (c == 36) || (c == 44);
`endif
      chk($sformatf("rpt_c%0d", c), 32'(press), 32'({3'b000, exp_bit, 1'b0}));
      if (c == 49) chk("rpt_level_held", 32'(level), 32'h02);
      if (c == 50) chk("rpt_level_rel", 32'(level), 32'h00);
      cnt += int'(press[1]);
      if (c == 44) btn_n[1] = 1'b1;
    end
`ifdef BTN_AUTOREPEAT_EN
    chk("rpt_total", 32'(cnt), 32'd5);
`else
    chk("rpt_total", 32'(cnt), 32'd1);
`endif
    $display("step value-inc hold: total strobes %0d", cnt);

    // Value-inc and value-dec pressed on the same edge.
    btn_n[2:1] = 2'b00;
    tick(6);
    chk("dual_press", 32'(press), 32'h06);
    chk("dual_level", 32'(level), 32'h06);
    tick(1);
    chk("dual_press_end", 32'(press), 32'h00);
    btn_n[2:1] = 2'b11;
    tick(6);
    chk("dual_rel_level", 32'(level), 32'h00);
    chk("dual_rel_press", 32'(press), 32'h00);
    $display("step dual press: done");

    // Reset while select-dec is held, then a fresh press after reset.
    btn_n[4] = 1'b0;
    tick(6);
    chk("sd_level", 32'(level), 32'h10);
    chk("sd_press", 32'(press), 32'h10);
    tick(3);
    chk("sd_held_level", 32'(level), 32'h10);
    chk("sd_held_press", 32'(press), 32'h00);
    rst = 1'b1;
    #1;
    chk("sd_async_level", 32'(level), 32'h00);
    chk("sd_async_press", 32'(press), 32'h00);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("sd_post_level_early", 32'(level), 32'h00);
    chk("sd_post_press_early", 32'(press), 32'h00);
    tick(1);
    chk("sd_post_level", 32'(level), 32'h10);
    chk("sd_post_press", 32'(press), 32'h10);
    tick(1);
    chk("sd_post_press_end", 32'(press), 32'h00);
    btn_n[4] = 1'b1;
    tick(8);
    chk("sd_final_level", 32'(level), 32'h00);
    $display("step reset while held: done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
